demux_tdm_4lanes: RTL and testbench

Time-division demultiplexer that receives the single 8-bit serial stream produced by the 4:1 mux tree on `clk_4f` and splits it back into four parallel lanes. Slot k of every 4-cycle frame belongs to lane k. Bytes are staged so that all four lanes update together once per frame, and each lane keeps its own valid flag. The block sits at the receive end of the lane-combining path and restores `Salida0..Salida3` with their `validSalida0..3` flags.

---
 rtl/demux_tdm_4lanes_if.sv | 31 +++
 rtl/demux_tdm_4lanes.sv | 109 ++++++++++
 tb/tb_demux_tdm_4lanes.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/demux_tdm_4lanes_if.sv
// Serial-in / four-lane-out bus of the TDM demultiplexer.
// The stream source drives the master side; the demultiplexer is the slave.
interface demux_tdm_4lanes_if #(
  parameter int BW = 8
);
  logic [BW-1:0] Entrada;
  logic          validEntrada;
  logic [BW-1:0] Salida0;
  logic [BW-1:0] Salida1;
  logic [BW-1:0] Salida2;
  logic [BW-1:0] Salida3;
  logic          validSalida0;
  logic          validSalida1;
  logic          validSalida2;
  logic          validSalida3;
  logic          palabra_lista;

  modport master (
    output Entrada, validEntrada,
    input  Salida0, Salida1, Salida2, Salida3,
    input  validSalida0, validSalida1, validSalida2, validSalida3,
    input  palabra_lista
  );

  modport slave (
    input  Entrada, validEntrada,
    output Salida0, Salida1, Salida2, Salida3,
    output validSalida0, validSalida1, validSalida2, validSalida3,
    output palabra_lista
  );
endinterface

// File: rtl/demux_tdm_4lanes.sv
// 1:4 time-division demultiplexer: slot k of each 4-cycle frame goes to lane k,
// all lanes update together at slot 3. Optional macro DEMUX_ALINEAR_EN aligns the frame to the first valid byte.
module demux_tdm_lane #(
  parameter int BW = 8
) (
  input  logic          clk_4f,
  input  logic          reset,
  input  logic          xfer,
  input  logic [BW-1:0] din,
  input  logic          din_v,
  output logic [BW-1:0] dout,
  output logic          dout_v
);
  // An invalid slot refreshes the flag but leaves the lane's last good byte in place.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      dout   <= '0;
      dout_v <= 1'b0;
    end else if (xfer) begin
      dout_v <= din_v;
      if (din_v) dout <= din;
    end
  end
endmodule

module demux_tdm_4lanes #(
  parameter int BW = 8
) (
  input  logic                 clk_4f,
  input  logic                 reset,
  demux_tdm_4lanes_if.slave    bus
);
  localparam int NUM_LANES = 4;

  logic [1:0]                          slot;
  logic [NUM_LANES-2:0][BW-1:0]        stage;
  logic [NUM_LANES-2:0]                stage_v;
  logic                                xfer;
  logic                                advance;
  logic                                pl_q;
  logic [NUM_LANES-1:0][BW-1:0]        lane_d;
  logic [NUM_LANES-1:0]                lane_v;
  logic [NUM_LANES-1:0][BW-1:0]        lane_q;
  logic [NUM_LANES-1:0]                lane_qv;

`ifdef DEMUX_ALINEAR_EN
  logic aligned;

  // Counter parks on slot 0 until the first valid byte marks the frame start.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) aligned <= 1'b0;
    else if (bus.validEntrada) aligned <= 1'b1;
  end

  assign advance = aligned | bus.validEntrada;
`else
  assign advance = 1'b1;
`endif

  assign xfer = (slot == 2'd3);

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      slot    <= '0;
      stage   <= '0;
      stage_v <= '0;
      pl_q    <= 1'b0;
    end else begin
      slot <= slot + {1'b0, advance};
      pl_q <= xfer;
      if (xfer) begin
        stage_v <= '0;
      end else begin
        for (int k = 0; k < NUM_LANES-1; k++) begin
          if (slot == 2'(k)) begin
            stage[k]   <= bus.Entrada;
            stage_v[k] <= bus.validEntrada;
          end
        end
      end
    end
  end

  // Lane 3 bypasses staging: its byte arrives on the transfer edge itself.
  assign lane_d = {bus.Entrada, stage};
  assign lane_v = {bus.validEntrada, stage_v};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux_tdm_lane #(.BW(BW)) u_lane (
      .clk_4f (clk_4f),
      .reset  (reset),
      .xfer   (xfer),
      .din    (lane_d[g]),
      .din_v  (lane_v[g]),
      .dout   (lane_q[g]),
      .dout_v (lane_qv[g])
    );
  end

  assign bus.Salida0       = lane_q[0];
  assign bus.Salida1       = lane_q[1];
  assign bus.Salida2       = lane_q[2];
  assign bus.Salida3       = lane_q[3];
  assign bus.validSalida0  = lane_qv[0];
  assign bus.validSalida1  = lane_qv[1];
  assign bus.validSalida2  = lane_qv[2];
  assign bus.validSalida3  = lane_qv[3];
  assign bus.palabra_lista = pl_q;
endmodule

// File: tb/tb_demux_tdm_4lanes.sv
// Self-checking bench for demux_tdm_4lanes: frame-level model compared every cycle,
// plus directed literal checks.
module tb_demux_tdm_4lanes;
  localparam int BW = 8;

  logic clk_4f = 1'b0;
  logic reset  = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  demux_tdm_4lanes_if #(.BW(BW)) bus ();

  demux_tdm_4lanes #(.BW(BW)) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk_4f = ~clk_4f;

  // Model: collect bytes into a frame; the 4th byte completes it and publishes all lanes.
  logic [BW-1:0] m_out [4] = '{default: '0};
  logic          m_v   [4] = '{default: 1'b0};
  logic          m_pl  = 1'b0;
  logic [BW-1:0] q_d [$];
  logic          q_v [$];
  bit            m_aligned = 1'b0;

  always @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin m_out[k] = '0; m_v[k] = 1'b0; end
      m_pl = 1'b0;
      q_d.delete(); q_v.delete();
      m_aligned = 1'b0;
    end else begin
      m_pl = 1'b0;
`ifdef DEMUX_ALINEAR_EN
      if (bus.validEntrada) m_aligned = 1'b1;
`else
      m_aligned = 1'b1;
`endif
      if (m_aligned) begin
        q_d.push_back(bus.Entrada);
        q_v.push_back(bus.validEntrada);
      end
      if (q_d.size() == 4) begin
        for (int k = 0; k < 4; k++) begin
          m_v[k] = q_v[k];
          if (q_v[k]) m_out[k] = q_d[k];
        end
        m_pl = 1'b1;
        q_d.delete(); q_v.delete();
      end
    end
  end

  function automatic logic [36:0] dut_vec();
    return {bus.Salida0, bus.Salida1, bus.Salida2, bus.Salida3,
            bus.validSalida0, bus.validSalida1, bus.validSalida2, bus.validSalida3,
            bus.palabra_lista};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_4f) begin
    if (chk_en)
      chk("cycle_model", 64'(dut_vec()),
          64'({m_out[0], m_out[1], m_out[2], m_out[3], m_v[0], m_v[1], m_v[2], m_v[3], m_pl}));
  end

  // Inputs change just after a falling edge; returns at the next falling edge.
  task automatic drive(input logic [BW-1:0] d, input logic v);
    #1;
    bus.Entrada      = d;
    bus.validEntrada = v;
    @(negedge clk_4f);
  endtask

  task automatic chk_word(input string nm, input logic [31:0] exp_d, input logic [3:0] exp_v,
                          input logic exp_pl);
    chk({nm, "_data"}, 64'({bus.Salida0, bus.Salida1, bus.Salida2, bus.Salida3}), 64'(exp_d));
    chk({nm, "_valid"}, 64'({bus.validSalida0, bus.validSalida1, bus.validSalida2, bus.validSalida3}),
        64'(exp_v));
    chk({nm, "_pl"}, 64'(bus.palabra_lista), 64'(exp_pl));
  endtask

  initial begin
    bus.Entrada      = '0;
    bus.validEntrada = 1'b0;
    repeat (2) @(negedge clk_4f);
    chk_word("reset_state", 32'h0, 4'h0, 1'b0);
    chk_en = 1'b1;

    // Continuous frames 0x10..0x1F, then two bytes of a fifth frame.
    #2 reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(8'(8'h10 + i), 1'b1);
      if (i == 7)  chk_word("frame2", 32'h14151617, 4'hF, 1'b1);
      if (i == 8)  chk_word("frame2_hold", 32'h14151617, 4'hF, 1'b0);
      if (i == 15) chk_word("frame4", 32'h1C1D1E1F, 4'hF, 1'b1);
    end

    // Reset mid-frame after slot 1 was sampled.
    #2 reset = 1'b1;
    #1 chk_word("async_reset", 32'h0, 4'h0, 1'b0);
    @(negedge clk_4f);
    #2 reset = 1'b0;
    drive(8'hA0, 1'b1);
    drive(8'hA1, 1'b1);
    drive(8'hA2, 1'b1);
    chk_word("post_reset_mid", 32'h0, 4'h0, 1'b0);
    drive(8'hA3, 1'b1);
    chk_word("post_reset", 32'hA0A1A2A3, 4'hF, 1'b1);

    // Partial valid after an all-0xAA word.
    repeat (4) drive(8'hAA, 1'b1);
    chk_word("all_aa", 32'hAAAAAAAA, 4'hF, 1'b1);
    drive(8'h55, 1'b1);
    drive(8'h66, 1'b0);
    drive(8'h77, 1'b1);
    drive(8'h88, 1'b0);
    chk_word("partial", 32'h55AA77AA, 4'hA, 1'b1);

    // Fully invalid frame still pulses palabra_lista.
    repeat (4) drive(8'h99, 1'b0);
    chk_word("all_invalid", 32'h55AA77AA, 4'h0, 1'b1);

    // Alignment stimulus: three idle slots, then C0..C3.
    #2 reset = 1'b1;
    bus.validEntrada = 1'b0;
    @(negedge clk_4f);
    #2 reset = 1'b0;
    repeat (3) drive(8'h00, 1'b0);
    chk_word("idle_no_pulse", 32'h0, 4'h0, 1'b0);
`ifdef DEMUX_ALINEAR_EN
    drive(8'hC0, 1'b1);
    chk_word("align_wait", 32'h0, 4'h0, 1'b0);
    drive(8'hC1, 1'b1);
    drive(8'hC2, 1'b1);
    drive(8'hC3, 1'b1);
    chk_word("aligned", 32'hC0C1C2C3, 4'hF, 1'b1);
    drive(8'h00, 1'b0);
`else
    drive(8'hC0, 1'b1);
    chk_word("unaligned1", 32'h000000C0, 4'h1, 1'b1);
    drive(8'hC1, 1'b1);
    drive(8'hC2, 1'b1);
    drive(8'hC3, 1'b1);
    drive(8'h00, 1'b0);
    chk_word("unaligned2", 32'hC1C2C3C0, 4'hE, 1'b1);
`endif
    repeat (6) drive(8'h00, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
